// File: rtl/simon_playback_sequencer.sv
// Simon playback sequencer: fetches each colour of the stored sequence,
// lights the matching LED with the tone for step_ms, then stays dark for
// gap_ms, and pulses done after the final gap.
module simon_playback_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = 5,
  parameter int TICK_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] ticks_per_milli,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        seq_len,
  input  logic [9:0]        step_ms,
  input  logic [9:0]        gap_ms,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        led,
  output logic              tone_en,
  output logic [1:0]        tone_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] idx;
  logic [5:0]        len_q;
  logic [9:0]        step_q;
  logic [9:0]        gap_q;
  logic [1:0]        colour;
  logic [TICK_W-1:0] tick_cnt;
  logic [9:0]        ms_cnt;

  logic [5:0]        len_clamped;
  logic [TICK_W-1:0] tpm_eff;
  logic [9:0]        step_eff;
  logic              ms_pulse;
  logic              on_end;
  logic              gap_end;
  logic              last_step;
  logic              step_advance;

  // Timebase decode, length clamp and end-of-phase conditions
  always_comb begin
    len_clamped = (int'(seq_len) > MAX_LEN) ? 6'(MAX_LEN) : seq_len;
    tpm_eff     = (ticks_per_milli == '0) ? TICK_W'(1) : ticks_per_milli;
    step_eff    = (step_q == '0) ? 10'd1 : step_q;
    ms_pulse    = (tick_cnt == tpm_eff - TICK_W'(1));
    on_end      = ms_pulse && (ms_cnt == step_eff - 10'd1);
    gap_end     = ms_pulse && (ms_cnt == gap_q - 10'd1);
    last_step   = ((int'(idx) + 1) == int'(len_q));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides everything, including start in IDLE
  always_comb begin
    state_next   = state;
    step_advance = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next = (len_clamped == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state_next = S_LOAD;
        S_LOAD:  state_next = S_ON;
        S_ON: begin
          if (on_end) begin
            if (gap_q != '0) begin
              state_next = S_GAP;
            end else if (last_step) begin
              state_next = S_DONE;
            end else begin
              state_next   = S_FETCH;
              step_advance = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            if (last_step) begin
              state_next = S_DONE;
            end else begin
              state_next   = S_FETCH;
              step_advance = 1'b1;
            end
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Step index, latched parameters and fetched colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      len_q  <= '0;
      step_q <= '0;
      gap_q  <= '0;
      colour <= '0;
    end else if (abort) begin
      idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q  <= len_clamped;
            step_q <= step_ms;
            gap_q  <= gap_ms;
            idx    <= '0;
          end
        end
        S_LOAD: colour <= mem_data;
        S_DONE: idx <= '0;
        default: begin
          if (step_advance) begin
            idx <= idx + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Tick and millisecond counters; any state change clears them, which
  // covers every entry to ON and GAP since neither can re-enter itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state_next != state) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state == S_ON || state == S_GAP) begin
      if (ms_pulse) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + 10'd1;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    mem_addr = (state == S_IDLE) ? '0 : idx;
    led      = '0;
    tone_en  = 1'b0;
    tone_sel = '0;
    if (state == S_ON) begin
      led      = 4'b0001 << colour;
      tone_en  = 1'b1;
      tone_sel = colour;
    end
  end

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Scoreboard bench: stimulus tasks queue expected LED runs / done pulses,
// a negedge monitor reconstructs them from the outputs and compares.
module tb_simon_playback_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ticks_per_milli;
  logic        start;
  logic        abort;
  logic [5:0]  seq_len;
  logic [9:0]  step_ms;
  logic [9:0]  gap_ms;
  logic [4:0]  mem_addr;
  logic [1:0]  mem_data;
  logic        busy;
  logic        done;
  logic [3:0]  led;
  logic        tone_en;
  logic [1:0]  tone_sel;

  simon_playback_sequencer #(.MAX_LEN(32), .ADDR_W(5), .TICK_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ticks_per_milli (ticks_per_milli),
    .start           (start),
    .abort           (abort),
    .seq_len         (seq_len),
    .step_ms         (step_ms),
    .gap_ms          (gap_ms),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .busy            (busy),
    .done            (done),
    .led             (led),
    .tone_en         (tone_en),
    .tone_sel        (tone_sel)
  );

  always #5 clk = ~clk;

  // Synchronous sequence memory: data valid one cycle after address
  logic [1:0] mem [0:31];
  always @(posedge clk) mem_data <= mem[mem_addr];

  // kind: 0 = completed step, 1 = done pulse, 2 = step cut short by abort
  typedef struct {
    int kind;
    int led;
    int sel;
    int addr;
    int on_len;
    int dark;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push(input int kind, input int l, input int s, input int a,
                      input int on, input int dk);
    ev_t e;
    e.kind = kind; e.led = l; e.sel = s; e.addr = a; e.on_len = on; e.dark = dk;
    exp_q.push_back(e);
  endtask

  // Monitor state
  int dark = 0;
  int on_len = 0;
  int run_dark, run_led, run_sel, run_addr;

  task automatic close_run(input int kind);
    ev_t e;
    check("event_expected", (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("run_kind", kind, e.kind);
      check("run_led", run_led, e.led);
      check("run_tone_sel", run_sel, e.sel);
      check("run_addr", run_addr, e.addr);
      if (e.kind == 0) begin
        check("run_on_cycles", on_len, e.on_len);
        check("run_dark_before", run_dark, e.dark);
      end
    end
    check("tone_off_after_run", tone_en, 0);
  endtask

  task automatic take_done();
    ev_t e;
    check("done_expected", (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("done_kind", 1, e.kind);
      check("done_dark_before", dark, e.dark);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      dark   = 0;
      on_len = 0;
    end else if (led != 4'b0000) begin
      if (on_len == 0) begin
        run_dark = dark;
        dark     = 0;
        run_led  = led;
        run_sel  = tone_sel;
        run_addr = mem_addr;
        check("tone_en_with_led", tone_en, 1);
      end else begin
        check("led_stable", led, run_led);
      end
      on_len++;
    end else begin
      if (on_len > 0) begin
        close_run(busy ? 0 : 2);
        on_len = 0;
      end
      if (done) begin
        take_done();
        dark = 0;
      end else if (busy) begin
        dark++;
      end else begin
        dark = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("playback_finished", busy, 0);
  endtask

  task automatic wait_led(input bit want_on, input int budget);
    int n = 0;
    while (((led != 4'b0000) != want_on) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("led_wait", (led != 4'b0000) ? 1 : 0, want_on ? 1 : 0);
  endtask

  // Queue the expected events for one playback, then run it
  task automatic run_seq(input int len, input int step, input int gap,
                         input int tp, input bit mid_start);
    int eff_len, tpe, on, gc;
    eff_len = (len > 32) ? 32 : len;
    tpe     = (tp == 0) ? 1 : tp;
    on      = ((step == 0) ? 1 : step) * tpe;
    gc      = gap * tpe;
    for (int i = 0; i < eff_len; i++)
      push(0, 1 << mem[i], int'(mem[i]), i, on, (i == 0) ? 2 : gc + 2);
    push(1, 0, 0, 0, 0, (eff_len == 0) ? 0 : gc);
    ticks_per_milli = 16'(tp);
    seq_len = 6'(len);
    step_ms = 10'(step);
    gap_ms  = 10'(gap);
    pulse_start();
    if (mid_start) begin
      wait_led(1'b1, 20);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(2000);
  endtask

  initial begin
    rst_n = 1'b1;
    ticks_per_milli = 16'd1;
    start = 1'b0;
    abort = 1'b0;
    seq_len = '0;
    step_ms = '0;
    gap_ms  = '0;
    for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_led", led, 0);
    check("reset_tone_en", tone_en, 0);
    check("reset_tone_sel", tone_sel, 0);
    check("reset_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two steps with sub-ms ticks and a gap
    mem[0] = 2'd2; mem[1] = 2'd0;
    run_seq(2, 3, 1, 2, 1'b0);

    // Single step, no gap: done follows the ON cycle directly
    mem[0] = 2'd3;
    run_seq(1, 1, 0, 1, 1'b0);

    // Zero length: immediate done, no LED
    run_seq(0, 5, 5, 1, 1'b0);

    // Abort in the middle of the second of three steps
    mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3;
    push(0, 2, 1, 0, 4, 2);
    push(2, 4, 2, 1, 0, 0);
    ticks_per_milli = 16'd1;
    seq_len = 6'd3; step_ms = 10'd4; gap_ms = 10'd1;
    pulse_start();
    begin
      int n = 0;
      while (!(mem_addr == 5'd1 && led != 4'b0000) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("reached_step1", mem_addr, 1);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_led", led, 0);
    check("abort_mem_addr", mem_addr, 0);
    repeat (10) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_with_abort_ignored", busy, 0);
    run_seq(1, 1, 0, 1, 1'b0);

    // Over-long sequence clamps to 32 steps; a mid-ON start is ignored
    for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
    run_seq(40, 1, 0, 1, 1'b1);

    // Async reset in the gap, then tpm=0 acting as tpm=1
    mem[0] = 2'd3;
    push(0, 8, 3, 0, 2, 2);
    ticks_per_milli = 16'd1;
    seq_len = 6'd1; step_ms = 10'd2; gap_ms = 10'd5;
    pulse_start();
    wait_led(1'b1, 20);
    wait_led(1'b0, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_led", led, 0);
    check("async_rst_tone_en", tone_en, 0);
    check("async_rst_done", done, 0);
    check("async_rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem[0] = 2'd1;
    run_seq(1, 2, 0, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
